cross_bar_slave_responder: RTL

//  Slave-side responder for one cross_bar_if slave port: accepts a request routed by the crossbar,

---
 rtl/cross_bar_slave_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cross_bar_slave_responder.sv
// Slave-side endpoint for one crossbar slave port: captures a request, acks it after a
// programmable stall, and services writes/reads against an internal word memory.
module cross_bar_slave_responder #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned ACK_DELAY    = 0,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_ACK,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, resp_q;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Slave-select bits and byte offset take no part in word addressing.
    logic addr_unused;
    assign addr_unused = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        mem_we_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = addr[IDX_W+1:2];
                    cmd_d   = cmd;
                    wdata_d = wdata;
                    if (ACK_DELAY == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_STALL;
                        cnt_d   = CNT_W'(ACK_DELAY - 1);
                    end
                end
            end
            S_STALL: begin
                if (cnt_q == '0) state_d = S_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACK: begin
                if (cmd_q) begin
                    mem_we_c = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    rd_d = mem_q[idx_q];
                    if (READ_LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(READ_LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // rd_d covers READ_LATENCY=1, where the memory word is fetched on the same edge.
        if (state_d == S_RESP) rdata_d = rd_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            ack_q   <= (state_d == S_ACK);
            resp_q  <= (state_d == S_RESP);
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[idx_q] <= wdata_q;
    end

    assign ack   = ack_q;
    assign resp  = resp_q;
    assign rdata = rdata_q;

endmodule
